// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the data memory: IDLE -> SETUP -> ACCESS -> DONE.
// Address/data are registered one cycle ahead of the strobes; completion is a one-cycle ack per port.
module dmem_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        busy_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_read_data_i
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] ADDR_LIMIT = DW'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;    // granted port of the current transaction
  logic            last_q, last_d;  // port granted by the previous transaction
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   mem_address_q, mem_address_d;
  logic [DW-1:0]   mem_write_data_q, mem_write_data_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;

  logic            win_c;
  logic [DW-1:0]   sel_addr_c, sel_wdata_c;
  logic            sel_we_c;

  function automatic logic illegal_addr(input logic [DW-1:0] a);
    return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
  endfunction

  // Winner selection: a tie goes to port 0 (fixed) or to the port not granted last.
  always_comb begin
    if (req0_i && req1_i) begin
      win_c = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      win_c = req1_i && !req0_i;
    end
    sel_addr_c  = win_c ? addr1_i  : addr0_i;
    sel_wdata_c = win_c ? wdata1_i : wdata0_i;
    sel_we_c    = win_c ? we1_i    : we0_i;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    last_d           = last_q;
    we_d             = we_q;
    ill_d            = ill_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    ack0_d           = 1'b0;
    ack1_d           = 1'b0;
    err0_d           = 1'b0;
    err1_d           = 1'b0;
    rdata0_d         = '0;
    rdata1_d         = '0;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          gnt_d            = win_c;
          we_d             = sel_we_c;
          ill_d            = illegal_addr(sel_addr_c);
          mem_address_d    = sel_addr_c;
          mem_write_data_d = sel_wdata_c;
          state_d          = S_SETUP;
        end
      end
      S_SETUP: begin
        mem_write_d = we_q && !ill_q;
        mem_read_d  = !we_q && !ill_q;
        state_d     = S_ACCESS;
      end
      S_ACCESS: begin
        // Read data is sampled at the end of the single strobe cycle.
        if (gnt_q) begin
          ack1_d   = 1'b1;
          err1_d   = ill_q;
          rdata1_d = (we_q || ill_q) ? '0 : mem_read_data_i;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = ill_q;
          rdata0_d = (we_q || ill_q) ? '0 : mem_read_data_i;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      gnt_q            <= 1'b0;
      last_q           <= 1'b1;
      we_q             <= 1'b0;
      ill_q            <= 1'b0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
      busy_q           <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      last_q           <= last_d;
      we_q             <= we_d;
      ill_q            <= ill_d;
      ack0_q           <= ack0_d;
      ack1_q           <= ack1_d;
      err0_q           <= err0_d;
      err1_q           <= err1_d;
      rdata0_q         <= rdata0_d;
      rdata1_q         <= rdata1_d;
      busy_q           <= busy_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
    end
  end

  assign ack0_o           = ack0_q;
  assign ack1_o           = ack1_q;
  assign err0_o           = err0_q;
  assign err1_o           = err1_q;
  assign rdata0_o         = rdata0_q;
  assign rdata1_o         = rdata1_q;
  assign busy_o           = busy_q;
  assign mem_address_o    = mem_address_q;
  assign mem_write_data_o = mem_write_data_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance with a memory model, plus a fixed-priority instance.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, busy, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

  logic        f_req0, f_req1;
  logic        f_ack0, f_ack1, f_err0, f_err1, f_busy, f_mem_read, f_mem_write;
  logic [31:0] f_rdata0, f_rdata1, f_mem_address, f_mem_write_data;

  dmem_arbiter #(.FIXED_PRIO(1'b0), .MEM_WORDS(256)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .req1_i(req1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .we0_i(we0), .we1_i(we1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .err0_o(err0), .err1_o(err1), .busy_o(busy),
    .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_read_data_i(mem_read_data)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1), .MEM_WORDS(256)) u_fp (
    .clk_i(clk), .reset_i(reset),
    .req0_i(f_req0), .req1_i(f_req1), .addr0_i(32'h0), .addr1_i(32'h4),
    .wdata0_i(32'h0), .wdata1_i(32'h0), .we0_i(1'b0), .we1_i(1'b0),
    .ack0_o(f_ack0), .ack1_o(f_ack1), .rdata0_o(f_rdata0), .rdata1_o(f_rdata1),
    .err0_o(f_err0), .err1_o(f_err1), .busy_o(f_busy),
    .mem_address_o(f_mem_address), .mem_write_data_o(f_mem_write_data),
    .mem_read_o(f_mem_read), .mem_write_o(f_mem_write), .mem_read_data_i(32'h0)
  );

  // Memory model: writes on the rising edge of the write strobe, reads combinationally.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge mem_write) begin
    if (mem_address < 32'd1024) mem[mem_address[9:2]] = mem_write_data;
  end
  assign mem_read_data = (mem_read && mem_address < 32'd1024) ? mem[mem_address[9:2]] : 32'h0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe monitor: write address/data must already be stable in the cycle before mem_write.
  int          wr_cnt = 0, rd_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic [31:0] addr_prev = 32'h0, wdata_prev = 32'h0;
  logic        wr_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_write) begin
      chk("wr_addr_stable", mem_address, addr_prev);
      chk("wr_data_stable", mem_write_data, wdata_prev);
      chk("wr_prev_low", 32'(wr_prev), 32'h0);
      wr_cnt++;
    end
    if (mem_read) rd_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    addr_prev  = mem_address;
    wdata_prev = mem_write_data;
    wr_prev    = mem_write;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = v; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = v; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(ack0 || ack1) && n < 12);
    chk({tag, "_ack_seen"}, 32'(ack0 | ack1), 32'h1);
  endtask

  task automatic txn(input string tag, input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic e, input logic [31:0] rd);
    int n, wr0, rd0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    set_req(p, 1'b1, w, a, d);
    wait_ack(tag, n);
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_ack"}, 32'(p == 0 ? ack0 : ack1), 32'h1);
    chk({tag, "_other_ack"}, 32'(p == 0 ? ack1 : ack0), 32'h0);
    chk({tag, "_err"}, 32'(p == 0 ? err0 : err1), 32'(e));
    chk({tag, "_rdata"}, p == 0 ? rdata0 : rdata1, rd);
    chk({tag, "_other_rdata"}, p == 0 ? rdata1 : rdata0, 32'h0);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), (w && !e) ? 32'd1 : 32'd0);
    chk({tag, "_rd_cnt"}, 32'(rd_cnt - rd0), (!w && !e) ? 32'd1 : 32'd0);
    set_req(p, 1'b0, w, a, d);
    step(1);
    chk({tag, "_ack_clr"}, 32'({ack0, ack1, err0, err1}), 32'h0);
    chk({tag, "_rdata_clr"}, rdata0 | rdata1, 32'h0);
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idle_cnt, a0, w0;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    f_req0 = 0; f_req1 = 0;
    step(2);
    chk("rst_flags", 32'({ack0, ack1, err0, err1, busy, mem_read, mem_write}), 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_rdata", rdata0 | rdata1, 32'h0);
    reset = 1'b0;
    step(1);

    // Single write then read on port 0
    txn("p0_wr", 0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("p0_wr_mem", mem[4], 32'hDEADBEEF);
    chk("p0_wr_addr_hold", mem_address, 32'h10);
    txn("p0_rd", 0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Port 1: legal accesses including the top word, then illegal ones
    txn("p1_wr0", 1, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0);
    txn("p1_wr_top", 1, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0);
    txn("p1_rd_top", 1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D);
    txn("p1_rd_mis", 1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    txn("p1_wr_oob", 1, 1'b1, 32'h400, 32'h12345678, 1'b1, 32'h0);
    chk("p1_oob_mem0", mem[0], 32'hA5A5A5A5);

    // Round-robin with both held; pointer starts at port 1 after reset
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr", n);
      chk("rr_spacing", 32'(n), (i == 0) ? 32'd3 : 32'd4);
      chk("rr_port", 32'(ack1), 32'(i % 2));
      chk("rr_both", 32'(ack0 & ack1), 32'h0);
      chk("rr_rdata0", rdata0, (i % 2 == 0) ? 32'hDEADBEEF : 32'h0);
      chk("rr_rdata1", rdata1, (i % 2 == 1) ? 32'hA5A5A5A5 : 32'h0);
    end
    set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    chk("rr_end_idle", 32'({busy, ack0, ack1}), 32'h0);

    // Back-to-back on port 1 with req held through ack
    set_req(1, 1'b1, 1'b0, 32'h0, 32'h0);
    wait_ack("b2b_first", n);
    chk("b2b_first_lat", 32'(n), 32'd3);
    n = 0;
    idle_cnt = 0;
    do begin
      step(1);
      n++;
      if (!busy) idle_cnt++;
    end while (!ack1 && n < 12);
    chk("b2b_spacing", 32'(n), 32'd4);
    chk("b2b_idle_cycles", 32'(idle_cnt), 32'd1);
    chk("b2b_rdata", rdata1, 32'hA5A5A5A5);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);

    // Reset during SETUP: write abandoned, no ack
    a0 = ack0_cnt;
    w0 = wr_cnt;
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h55);
    step(1);
    chk("setup_busy", 32'(busy), 32'h1);
    chk("setup_addr", mem_address, 32'h20);
    reset = 1'b1;
    #1;
    chk("rst_async_flags", 32'({busy, mem_write, mem_read}), 32'h0);
    chk("rst_async_addr", mem_address, 32'h0);
    chk("rst_async_wdata", mem_write_data, 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    reset = 1'b0;
    step(6);
    chk("setup_rst_no_ack", 32'(ack0_cnt - a0), 32'h0);
    chk("setup_rst_no_wr", 32'(wr_cnt - w0), 32'h0);
    chk("setup_rst_mem", mem[8], 32'h0);

    // Reset during ACCESS: write already committed, no ack
    set_req(0, 1'b1, 1'b1, 32'h24, 32'h66);
    step(2);
    chk("access_wr_high", 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    chk("access_rst_wr_low", 32'(mem_write), 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    reset = 1'b0;
    step(6);
    chk("access_rst_mem", mem[9], 32'h66);
    chk("access_rst_no_ack", 32'(ack0_cnt - a0), 32'h0);

    // Fixed priority: port 0 wins every tie, port 1 served once req0 drops
    f_req0 = 1'b1;
    f_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) f_req0 = 1'b0;
      n = 0;
      do begin
        step(1);
        n++;
      end while (!(f_ack0 || f_ack1) && n < 12);
      chk("fp_ack_seen", 32'(f_ack0 | f_ack1), 32'h1);
      chk("fp_port", 32'({f_ack1, f_ack0}), (i < 3) ? 32'h1 : 32'h2);
      chk("fp_err", 32'(f_err0 | f_err1), 32'h0);
    end
    f_req1 = 1'b0;
    step(1);
    chk("fp_idle", 32'({f_busy, f_ack0, f_ack1}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
